// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: upstream instruction handshake, register-file read port
// and downstream ALU issue bus of the decode/issue stage.
// master: the surrounding pipeline (fetch, register file, execute stage).
// slave:  the issue stage itself.
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [31:0]     in_pc;
    logic [4:0]      rf_rs1_addr;
    logic [4:0]      rf_rs2_addr;
    logic [XLEN-1:0] rf_rs1_data;
    logic [XLEN-1:0] rf_rs2_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [3:0]      out_field;
    logic [4:0]      out_rd;
    logic            out_rd_we;
    logic [31:0]     out_pc;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, rf_rs1_data, rf_rs2_data, flush, out_ready,
        input  in_ready, rf_rs1_addr, rf_rs2_addr, out_valid, out_op1, out_op2,
               out_field, out_rd, out_rd_we, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, rf_rs1_data, rf_rs2_data, flush, out_ready,
        output in_ready, rf_rs1_addr, rf_rs2_addr, out_valid, out_op1, out_op2,
               out_field, out_rd, out_rd_we, out_pc, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes the RV32I integer-computational subset, reads the
// register file and issues ALU operands through a MAIN + SKID buffer.
// Optional macro ALU_ISSUE_PERF_EN adds perf_issued / perf_stall counters.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_stage_if.slave   bus
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]        perf_issued,
    output logic [31:0]        perf_stall
`endif
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_t;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [3:0]      field;
        logic [4:0]      rd;
        logic            rd_we;
        logic [31:0]     pc;
        logic            illegal;
    } entry_t;

    opcode_t     w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic        w_legal;
    logic [3:0]  w_field;
    entry_t      w_dec;

    entry_t      r_main, r_skid, w_main_n, w_skid_n;
    logic        r_main_valid, r_skid_valid, w_main_valid_n, w_skid_valid_n;
    logic        r_in_ready, w_in_ready_n;
    logic        w_accept, w_main_free;

    assign w_opcode = opcode_t'(bus.in_instr[6:0]);
    assign w_funct3 = bus.in_instr[14:12];
    assign w_funct7 = bus.in_instr[31:25];
    assign w_rd     = bus.in_instr[11:7];

    assign bus.rf_rs1_addr = bus.in_instr[19:15];
    assign bus.rf_rs2_addr = bus.in_instr[24:20];

    // Decode the incoming instruction into an issue entry
    always_comb begin
        w_dec    = '0;
        w_legal  = 1'b0;
        w_field  = 4'b0000;
        w_dec.rd = w_rd;
        w_dec.pc = bus.in_pc;
        case (w_opcode)
            OPC_OP: begin
                w_dec.op1 = bus.rf_rs1_data;
                w_dec.op2 = bus.rf_rs2_data;
                w_field   = {bus.in_instr[30], w_funct3};
                w_legal   = (w_funct7 == 7'b0000000) ||
                            ((w_funct7 == 7'b0100000) &&
                             ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                w_dec.op1 = bus.rf_rs1_data;
                w_dec.op2 = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
                w_field   = {1'b0, w_funct3};
                w_legal   = 1'b1;
                if (w_funct3 == 3'b001) begin
                    w_dec.op2 = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
                    w_legal   = (w_funct7 == 7'b0000000);
                end else if (w_funct3 == 3'b101) begin
                    w_dec.op2 = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
                    w_field   = {bus.in_instr[30], w_funct3};
                    w_legal   = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                end
            end
            OPC_LUI: begin
                w_dec.op2 = {bus.in_instr[31:12], 12'b0};
                w_legal   = 1'b1;
            end
            OPC_AUIPC: begin
                w_dec.op1 = bus.in_pc;
                w_dec.op2 = {bus.in_instr[31:12], 12'b0};
                w_legal   = 1'b1;
            end
            default: ;
        endcase
        w_dec.illegal = !w_legal;
        w_dec.field   = w_legal ? w_field : 4'b0000;
        w_dec.rd_we   = w_legal && (w_rd != 5'd0);
    end

    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_main_free = !r_main_valid || bus.out_ready;

    // Next buffer contents: flush wins, SKID refills MAIN ahead of new input
    always_comb begin
        w_main_n       = r_main;
        w_skid_n       = r_skid;
        w_main_valid_n = r_main_valid;
        w_skid_valid_n = r_skid_valid;
        if (bus.flush) begin
            w_main_valid_n = 1'b0;
            w_skid_valid_n = 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                w_main_n       = r_skid;
                w_main_valid_n = 1'b1;
                w_skid_n       = w_dec;
                w_skid_valid_n = w_accept;
            end else begin
                w_main_n       = w_dec;
                w_main_valid_n = w_accept;
            end
        end else if (w_accept) begin
            w_skid_n       = w_dec;
            w_skid_valid_n = 1'b1;
        end
        w_in_ready_n = !w_skid_valid_n;
    end

    // Buffer and ready registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            r_main       <= w_main_n;
            r_skid       <= w_skid_n;
            r_main_valid <= w_main_valid_n;
            r_skid_valid <= w_skid_valid_n;
            r_in_ready   <= w_in_ready_n;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_main_valid;
    assign bus.out_op1     = r_main.op1;
    assign bus.out_op2     = r_main.op2;
    assign bus.out_field   = r_main.field;
    assign bus.out_rd      = r_main.rd;
    assign bus.out_rd_we   = r_main.rd_we;
    assign bus.out_pc      = r_main.pc;
    assign bus.out_illegal = r_main.illegal;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] r_perf_issued, r_perf_stall;

    // Issue and stall counters; wrap naturally and ignore flush
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (r_main_valid && bus.out_ready)  r_perf_issued <= r_perf_issued + 32'd1;
            if (r_main_valid && !bus.out_ready) r_perf_stall  <= r_perf_stall + 32'd1;
        end
    end

    assign perf_issued = r_perf_issued;
    assign perf_stall  = r_perf_stall;
`endif

endmodule
